// File: rtl/npu_cube_csa_accum_pkg.sv
// npu_cube_acc_pkg: FSM encoding and width-check helpers shared by the carry-save accumulator
package npu_cube_acc_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        OUTPUT  = 2'd3
    } state_t;
    // Sum term plus carry term shifted by one needs two guard bits above bitwidth.
    localparam int ACC_MARGIN = 2;
    function automatic bit width_ok(input int bw, input int aw);
        return aw >= bw + ACC_MARGIN;
    endfunction
endpackage

// File: rtl/npu_cube_csa_accum_if.sv
// npu_cube_csa_accum_if: input beat and output result handshakes; Out_Count exists only with NPU_CUBE_ACC_CNT_EN
interface npu_cube_csa_accum_if #(
    parameter int bitwidth = 8,
    parameter int accwidth = 20,
    parameter int cntwidth = 8
);
    logic                In_Valid;
    logic                In_Ready;
    logic [bitwidth-1:0] In_Sum;
    logic [bitwidth-1:0] In_Carry;
    logic                In_Last;
    logic                Out_Valid;
    logic                Out_Ready;
    logic [accwidth-1:0] Out_Result;
`ifdef NPU_CUBE_ACC_CNT_EN
    logic [cntwidth-1:0] Out_Count;
    modport master(output In_Valid, In_Sum, In_Carry, In_Last, Out_Ready,
                   input In_Ready, Out_Valid, Out_Result, Out_Count);
    modport slave(input In_Valid, In_Sum, In_Carry, In_Last, Out_Ready,
                  output In_Ready, Out_Valid, Out_Result, Out_Count);
`else
    modport master(output In_Valid, In_Sum, In_Carry, In_Last, Out_Ready,
                   input In_Ready, Out_Valid, Out_Result);
    modport slave(input In_Valid, In_Sum, In_Carry, In_Last, Out_Ready,
                  output In_Ready, Out_Valid, Out_Result);
`endif
endinterface

// File: rtl/npu_cube_csa_accum_csa32.sv
// npu_cube_csa32: width-n row of 3:2 full adders; carry is unshifted (bit i weighs 2^(i+1))
module npu_cube_csa32 #(
    parameter int n = 8
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic [n-1:0] c,
    output logic [n-1:0] sum,
    output logic [n-1:0] carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/npu_cube_csa_accum.sv
// npu_cube_csa_accum: carry-save group accumulator with one CPA per group; Out_Count gated by NPU_CUBE_ACC_CNT_EN
module npu_cube_csa_accum
    import npu_cube_acc_pkg::*;
#(
    parameter int bitwidth = 8,
    parameter int accwidth = 20,
    parameter int cntwidth = 8
) (
    input  logic clk,
    input  logic rst,
    npu_cube_csa_accum_if.slave bus
);
    state_t              state, state_n;
    logic [accwidth-1:0] acc_s, acc_c, s_term, c_term, r1_s, r1_c, r2_s, r2_c, result;
    logic                accept;

    assign s_term         = accwidth'(bus.In_Sum);
    assign c_term         = accwidth'(bus.In_Carry) << 1;
    assign bus.In_Ready   = !rst && (state == IDLE || state == ACCUM);
    assign bus.Out_Valid  = state == OUTPUT;
    assign bus.Out_Result = result;
    assign accept         = bus.In_Valid && bus.In_Ready;

    npu_cube_csa32 #(.n(accwidth)) row0 (
        .a(acc_s), .b(acc_c), .c(s_term), .sum(r1_s), .carry(r1_c)
    );
    npu_cube_csa32 #(.n(accwidth)) row1 (
        .a(r1_s), .b(r1_c << 1), .c(c_term), .sum(r2_s), .carry(r2_c)
    );

    // next-state: accumulate until Last, one resolve cycle, then hold result until taken
    always_comb begin
        state_n = state;
        case (state)
            IDLE, ACCUM: if (accept) state_n = bus.In_Last ? RESOLVE : ACCUM;
            RESOLVE:     state_n = OUTPUT;
            default:     if (bus.Out_Ready) state_n = IDLE;
        endcase
    end

    // state, redundant accumulator and registered CPA result
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc_s  <= '0;
            acc_c  <= '0;
            result <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                acc_s <= r2_s;
                acc_c <= r2_c << 1;
            end else if (state == OUTPUT && bus.Out_Ready) begin
                acc_s <= '0;
                acc_c <= '0;
            end
            if (state == RESOLVE) result <= acc_s + acc_c;
        end
    end

`ifdef NPU_CUBE_ACC_CNT_EN
    logic [cntwidth-1:0] cnt, count;
    assign bus.Out_Count = count;

    // saturating beat counter, restarted by the first beat of each group
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            count <= '0;
        end else begin
            if (accept) cnt <= state == IDLE ? cntwidth'(1) : (&cnt ? cnt : cnt + 1'b1);
            else if (state == IDLE) cnt <= '0;
            if (state == RESOLVE) count <= cnt;
        end
    end
`endif
endmodule

// File: tb/tb_npu_cube_csa_accum.sv
// tb_npu_cube_csa_accum: table and random groups on a 20-bit and a 10-bit accumulator driven in lockstep
module tb_npu_cube_csa_accum;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    npu_cube_csa_accum_if #(.bitwidth(8), .accwidth(20), .cntwidth(8)) bus_a ();
    npu_cube_csa_accum_if #(.bitwidth(8), .accwidth(10), .cntwidth(2)) bus_b ();

    npu_cube_csa_accum #(.bitwidth(8), .accwidth(20), .cntwidth(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    npu_cube_csa_accum #(.bitwidth(8), .accwidth(10), .cntwidth(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    assign bus_b.In_Valid  = bus_a.In_Valid;
    assign bus_b.In_Sum    = bus_a.In_Sum;
    assign bus_b.In_Carry  = bus_a.In_Carry;
    assign bus_b.In_Last   = bus_a.In_Last;
    assign bus_b.Out_Ready = bus_a.Out_Ready;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         n;
        logic [7:0] s;
        logic [7:0] c;
        int         hold;
        longint     ea;
        longint     eb;
        int         ca;
        int         cb;
    } vec_t;
    vec_t tbl[5];

    logic [7:0] qs[$];
    logic [7:0] qc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint model(input int aw);
        longint t = 0;
        foreach (qs[i]) t += longint'(qs[i]) + 2 * longint'(qc[i]);
        return t % (longint'(1) << aw);
    endfunction

    function automatic int sat(input int n, input int w);
        return n > (1 << w) - 1 ? (1 << w) - 1 : n;
    endfunction

    task automatic run_group(input string tag, input int hold, input longint ea, input longint eb,
                             input int ca, input int cb);
        bit rdy_ok = 1'b1;
        bit stable = 1'b1;
        bus_a.Out_Ready = hold == 0;
        foreach (qs[i]) begin
            @(negedge clk);
            bus_a.In_Valid = 1'b1;
            bus_a.In_Sum   = qs[i];
            bus_a.In_Carry = qc[i];
            bus_a.In_Last  = i == qs.size() - 1;
            rdy_ok &= bus_a.In_Ready && bus_b.In_Ready;
        end
        chk({tag, " in_ready_each_beat"}, 64'(rdy_ok), 1);
        @(negedge clk);
        bus_a.In_Valid = hold > 0;
        bus_a.In_Sum   = 8'hAA;
        bus_a.In_Carry = 8'h55;
        bus_a.In_Last  = 1'b1;
        chk({tag, " resolve_rdy_vld"}, {bus_a.In_Ready, bus_a.Out_Valid, bus_b.In_Ready, bus_b.Out_Valid}, 4'b0000);
        @(negedge clk);
        chk({tag, " output_rdy_vld"}, {bus_a.In_Ready, bus_a.Out_Valid, bus_b.In_Ready, bus_b.Out_Valid}, 4'b0101);
        chk({tag, " result_a"}, 64'(bus_a.Out_Result), ea);
        chk({tag, " result_b"}, 64'(bus_b.Out_Result), eb);
`ifdef NPU_CUBE_ACC_CNT_EN
        chk({tag, " count_a"}, 64'(bus_a.Out_Count), 64'(ca));
        chk({tag, " count_b"}, 64'(bus_b.Out_Count), 64'(cb));
`endif
        repeat (hold) begin
            @(negedge clk);
            stable &= bus_a.Out_Valid && bus_b.Out_Valid && !bus_a.In_Ready && !bus_b.In_Ready
                      && 64'(bus_a.Out_Result) == ea && 64'(bus_b.Out_Result) == eb;
        end
        if (hold > 0) chk({tag, " hold_stable"}, 64'(stable), 1);
        bus_a.Out_Ready = 1'b1;
        bus_a.In_Valid  = 1'b0;
        @(negedge clk);
        chk({tag, " released"}, {bus_a.In_Ready, bus_a.Out_Valid, bus_b.In_Ready, bus_b.Out_Valid}, 4'b1010);
    endtask

    initial begin
        tbl[0] = '{1, 8'h0F, 8'h01, 0, 17, 17, 1, 1};
        tbl[1] = '{4, 8'hFF, 8'hFF, 0, 3060, 1012, 4, 3};
        tbl[2] = '{2, 8'hFF, 8'hFF, 0, 1530, 506, 2, 2};
        tbl[3] = '{3, 8'hFF, 8'hFF, 5, 2295, 247, 3, 3};
        tbl[4] = '{6, 8'h00, 8'h00, 0, 0, 0, 6, 3};
        bus_a.In_Valid  = 1'b0;
        bus_a.In_Sum    = '0;
        bus_a.In_Carry  = '0;
        bus_a.In_Last   = 1'b0;
        bus_a.Out_Ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_rdy_vld", {bus_a.In_Ready, bus_a.Out_Valid, bus_b.In_Ready, bus_b.Out_Valid}, 4'b0000);
        chk("reset_results", {44'(bus_a.Out_Result), 20'(bus_b.Out_Result)}, 0);
`ifdef NPU_CUBE_ACC_CNT_EN
        chk("reset_counts", {bus_a.Out_Count, bus_b.Out_Count}, 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {bus_a.In_Ready, bus_b.In_Ready}, 2'b11);

        for (int k = 0; k < 5; k++) begin
            qs.delete();
            qc.delete();
            repeat (tbl[k].n) begin
                qs.push_back(tbl[k].s);
                qc.push_back(tbl[k].c);
            end
            run_group($sformatf("tbl%0d", k), tbl[k].hold, tbl[k].ea, tbl[k].eb, tbl[k].ca, tbl[k].cb);
        end

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_a.In_Valid = 1'b1;
            bus_a.In_Sum   = 8'hFF;
            bus_a.In_Carry = 8'hFF;
            bus_a.In_Last  = 1'b0;
        end
        @(negedge clk);
        bus_a.In_Valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midgroup_rst_ready", {bus_a.In_Ready, bus_b.In_Ready}, 2'b00);
        rst = 1'b0;
        @(negedge clk);
        chk("midgroup_rst_state", {bus_a.In_Ready, bus_a.Out_Valid, bus_b.In_Ready, bus_b.Out_Valid}, 4'b1010);
        chk("midgroup_rst_result", {44'(bus_a.Out_Result), 20'(bus_b.Out_Result)}, 0);
        qs = '{8'h01};
        qc = '{8'h00};
        run_group("post_rst", 0, 1, 1, 1, 1);

        bus_a.Out_Ready = 1'b0;
        @(negedge clk);
        bus_a.In_Valid = 1'b1;
        bus_a.In_Sum   = 8'h10;
        bus_a.In_Carry = 8'h00;
        bus_a.In_Last  = 1'b1;
        @(negedge clk);
        bus_a.In_Valid = 1'b0;
        @(negedge clk);
        chk("midoutput_valid", {bus_a.Out_Valid, bus_b.Out_Valid}, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        chk("midoutput_rst_valid", {bus_a.Out_Valid, bus_b.Out_Valid}, 2'b00);
        chk("midoutput_rst_result", {44'(bus_a.Out_Result), 20'(bus_b.Out_Result)}, 0);
        rst = 1'b0;
        bus_a.Out_Ready = 1'b1;
        @(negedge clk);
        chk("midoutput_rst_ready", {bus_a.In_Ready, bus_b.In_Ready}, 2'b11);
        qs = '{8'h03};
        qc = '{8'h00};
        run_group("post_out_rst", 0, 3, 3, 1, 1);

        for (int g = 0; g < 20; g++) begin
            int n;
            n = $urandom_range(1, 6);
            qs.delete();
            qc.delete();
            repeat (n) begin
                qs.push_back(8'($urandom));
                qc.push_back(8'($urandom));
            end
            run_group($sformatf("rnd%0d", g), $urandom_range(0, 2), model(20), model(10), sat(n, 8), sat(n, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
